decode_stage: RTL
=================

Name: decode_stage

Overview:
- Registered RV32I instruction-decode stage with a valid/ready handshake on both sides, an optional skid entry, flush support and illegal-instruction detection.
- Generalises the existing combinational field decoder in three ways:
  - parametrised XLEN;
  - adds AUIPC, MISC_MEM and SYSTEM opcodes;
  - tags each instruction with its format.
- Sits between the IF/ID boundary and the register-file read / hazard unit.

Parameters:
- XLEN, 32, datapath width; must be 32 or 64. out_imm and out_pc are sign-extended or sized to XLEN.
- SKID_EN, 1, 1 adds one skid entry so that in_ready is a registered signal; 0 means a single output register with combinational in_ready.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  squash all held and incoming instructions
- in_valid  in  1  fetch has an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  32  raw instruction word
- in_pc  in  XLEN  PC of in_instr
- out_valid  out  1  decoded bundle is valid
- out_ready  in  1  downstream accepts the bundle
- out_pc  out  XLEN  PC of the bundle
- out_opcode  out  7  instr[6:0]
- out_rd, out_rs1, out_rs2  out  5 each  register indices; 0 when unused by the format
- out_funct3  out  3  0 when unused
- out_funct7  out  7  non-zero only for OP
- out_imm  out  XLEN  decoded immediate
- out_fmt  out  3  fmt_e: R, I, S, B, U, J, NONE
- out_illegal  out  1  instruction is illegal
- out_muldiv  out  1  instruction is an M-extension op

Behaviour:
- Reset (synchronous, active-high):
  - all outputs are 0 and the skid entry is empty;
  - in_ready is 0 while reset is high and 1 in the first cycle after it.
- Transfers:
  - input transfer = in_valid && in_ready;
  - output transfer = out_valid && out_ready.
  - Latency is 1 cycle: a bundle accepted at edge N is presented on the outputs after edge N.
- Field gating:
  - rd is valid for OP, OP_IMM, JALR, LOAD, LUI, AUIPC, JAL, SYSTEM.
  - rs1 is valid for OP, OP_IMM, JALR, LOAD, STORE, BRANCH, SYSTEM.
  - rs2 is valid for OP, STORE, BRANCH.
  - funct3 is valid for every format except U and J.
- Immediates:
  - I, S, B and J immediates are sign-extended to XLEN.
  - U immediate is {instr[31:12], 12'b0}, sign-extended to XLEN.
  - The B and J immediate LSB is 0.
  - R-format immediate is 0.
- Illegal conditions:
  - instr[1:0] != 2'b11;
  - unknown opcode;
  - OP funct7 not in {0x00, 0x20}, or funct7 = 0x20 with funct3 not in {000, 101};
  - OP_IMM shift with an illegal funct7 (XLEN=64: funct6 checked instead);
  - JALR funct3 != 0;
  - BRANCH funct3 in {010, 011};
  - LOAD funct3 in {111}, plus {011, 110} when XLEN=32;
  - STORE funct3 > 010 when XLEN=32, > 011 when XLEN=64.
- Illegal handling:
  - all fields and the immediate are forced to 0, out_illegal=1, and out_pc is kept;
  - the bundle is still delivered with out_valid=1 so that a trap can be raised.
- SKID_EN=0:
  - in_ready = !out_valid || out_ready.
- SKID_EN=1:
  - in_ready = skid entry empty (registered).
  - If out_valid && !out_ready and an input transfer occurs, the new bundle goes into the skid entry.
  - On an output transfer, the skid contents move to the output register; otherwise the new input does.
  - Program order is always preserved.
- Flush:
  - highest priority below reset;
  - clears out_valid and the skid entry at the next edge;
  - an input accepted in the flush cycle is dropped;
  - in_ready follows the normal rule during the flush cycle.
- Holding: outputs stay stable while out_valid && !out_ready.

Optional Feature:
- Macro DECODE_RV32M_EN.
- Defined: OP with funct7 = 0000001 is legal, sets out_muldiv=1, and outputs funct7 = 0x01.
- Undefined: that encoding is illegal and out_muldiv is tied to 0.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams (OP, OP_IMM, JALR, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, MISC_MEM, SYSTEM);
  - fmt_e enum;
  - decoded_t packed struct containing all out_* fields except valid.
- Sub-module decode_fields: purely combinational; instr -> decoded_t; parametrised on XLEN.
- decode_stage contains only the handshake, skid and flush logic, and stores decoded_t.

Test Plan:
- ADDI: in_instr=0xFFF10093, in_pc=0x100, out_ready=1 -> next cycle out_rd=1, out_rs1=2, out_rs2=0, out_imm=0xFFFFFFFF, fmt=I, illegal=0, out_pc=0x100.
- Backpressure with SKID_EN=1: out_ready=0, push A then B -> A is held on the outputs, B is in skid, in_ready=0, and C is stalled. Raise out_ready -> A, B, C appear on consecutive cycles.
- Illegal instructions:
  - 0x00000000 -> out_valid=1, out_illegal=1, all fields 0;
  - 0x0000A003 (LOAD, funct3=010... use funct3=111: 0x00007003) -> illegal=1.
- MUL 0x022081B3:
  - with DECODE_RV32M_EN -> rd=3, rs1=1, rs2=2, muldiv=1;
  - without it -> illegal=1.
- Flush with out_valid=1 and skid full, plus a simultaneous input -> next cycle out_valid=0, skid empty, and the input is dropped.
- Assert reset while out_ready=0 and the stage is full -> next cycle all outputs are 0; the cycle after that in_ready=1.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared opcode constants, instruction format tags and the decoded bundle for the decode stage.
// Datapath fields are MAX_XLEN wide so one struct serves both RV32 and RV64 builds.
package decode_pkg;

  localparam int MAX_XLEN = 64;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] MISC_MEM = 7'b0001111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE
  } fmt_e;

  typedef struct packed {
    logic [MAX_XLEN-1:0] pc;
    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [MAX_XLEN-1:0] imm;
    fmt_e                fmt;
    logic                illegal;
    logic                muldiv;
  } decoded_t;

endpackage

// File: rtl/decode_fields.sv
// Combinational RV32I/RV64I field decoder: raw instruction word to decoded bundle.
// Define DECODE_RV32M_EN to accept the M-extension OP encodings (funct7 = 0000001).
module decode_fields
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output decoded_t        dec
);

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic [MAX_XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [MAX_XLEN-1:0] imm;
  logic                legal, rd_en, rs1_en, rs2_en, f7_en, muldiv;
  fmt_e                fmt;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i = {{52{instr[31]}}, instr[31:20]};
  assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
  assign imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    legal  = 1'b1;
    rd_en  = 1'b0;
    rs1_en = 1'b0;
    rs2_en = 1'b0;
    f7_en  = 1'b0;
    muldiv = 1'b0;
    fmt    = FMT_NONE;
    imm    = '0;
    dec    = '0;
    case (opcode)
      OP: begin
        fmt = FMT_R; rd_en = 1'b1; rs1_en = 1'b1; rs2_en = 1'b1; f7_en = 1'b1;
        legal = (funct7 == 7'h00) ||
                (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
`ifdef DECODE_RV32M_EN
        if (funct7 == 7'h01) begin
          legal  = 1'b1;
          muldiv = 1'b1;
        end
`endif
      end
      OP_IMM: begin
        fmt = FMT_I; rd_en = 1'b1; rs1_en = 1'b1; imm = imm_i;
        // RV64 shifts carry a 6-bit shamt, so only funct6 constrains the encoding
        if (funct3 == 3'b001)
          legal = (XLEN == 64) ? (instr[31:26] == 6'h00) : (funct7 == 7'h00);
        else if (funct3 == 3'b101)
          legal = (XLEN == 64) ? (instr[31:26] == 6'h00 || instr[31:26] == 6'h10)
                               : (funct7 == 7'h00 || funct7 == 7'h20);
      end
      JALR: begin
        fmt = FMT_I; rd_en = 1'b1; rs1_en = 1'b1; imm = imm_i;
        legal = (funct3 == 3'b000);
      end
      LOAD: begin
        fmt = FMT_I; rd_en = 1'b1; rs1_en = 1'b1; imm = imm_i;
        legal = (funct3 != 3'b111) &&
                !(XLEN == 32 && (funct3 == 3'b011 || funct3 == 3'b110));
      end
      STORE: begin
        fmt = FMT_S; rs1_en = 1'b1; rs2_en = 1'b1; imm = imm_s;
        legal = (funct3 <= ((XLEN == 64) ? 3'd3 : 3'd2));
      end
      BRANCH: begin
        fmt = FMT_B; rs1_en = 1'b1; rs2_en = 1'b1; imm = imm_b;
        legal = !(funct3 == 3'b010 || funct3 == 3'b011);
      end
      LUI, AUIPC: begin
        fmt = FMT_U; rd_en = 1'b1; imm = imm_u;
      end
      JAL: begin
        fmt = FMT_J; rd_en = 1'b1; imm = imm_j;
      end
      MISC_MEM: fmt = FMT_NONE;
      SYSTEM: begin
        fmt = FMT_I; rd_en = 1'b1; rs1_en = 1'b1; imm = imm_i;
      end
      default: legal = 1'b0;
    endcase
    if (instr[1:0] != 2'b11)
      legal = 1'b0;

    // Illegal words keep only their PC so the trap handler can report it
    if (legal) begin
      dec.opcode = opcode;
      dec.rd     = rd_en  ? instr[11:7]  : 5'd0;
      dec.rs1    = rs1_en ? instr[19:15] : 5'd0;
      dec.rs2    = rs2_en ? instr[24:20] : 5'd0;
      dec.funct3 = (fmt == FMT_U || fmt == FMT_J) ? 3'd0 : funct3;
      dec.funct7 = f7_en ? funct7 : 7'd0;
      dec.imm    = imm;
      dec.fmt    = fmt;
      dec.muldiv = muldiv;
    end
    dec.pc      = MAX_XLEN'(pc);
    dec.illegal = !legal;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready handshake, optional skid entry and flush.
// Field decoding lives in decode_fields; DECODE_RV32M_EN is honoured there.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output fmt_e            out_fmt,
  output logic            out_illegal,
  output logic            out_muldiv
);

  decoded_t dec, out_q, skid_q;
  logic     out_valid_q, skid_valid_q, out_free, in_xfer;

  decode_fields #(.XLEN(XLEN)) u_fields (
    .instr (in_instr),
    .pc    (in_pc),
    .dec   (dec)
  );

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = !reset && (SKID_EN ? !skid_valid_q : out_free);
  assign in_xfer  = in_valid && in_ready;

  // A free output register drains the skid first so program order holds
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      if (SKID_EN && skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= in_xfer;
        if (in_xfer)
          out_q <= dec;
      end
    end else if (SKID_EN && in_xfer) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_q.pc[XLEN-1:0];
  assign out_opcode  = out_q.opcode;
  assign out_rd      = out_q.rd;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_funct3  = out_q.funct3;
  assign out_funct7  = out_q.funct7;
  assign out_imm     = out_q.imm[XLEN-1:0];
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;
  assign out_muldiv  = out_q.muldiv;

  if (XLEN < MAX_XLEN) begin : g_narrow
    logic unused_hi;
    assign unused_hi = ^{out_q.pc[MAX_XLEN-1:XLEN], out_q.imm[MAX_XLEN-1:XLEN]};
  end

endmodule
